// File: rtl/cpu_cu_ws_if.sv
// Control-unit boundary: IR/flags/memory handshake in, datapath and memory controls out.
interface cpu_cu_ws_if #(
    parameter int unsigned RA_W  = 3,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned IW = 7 + 3 * RA_W;

    logic [IW-1:0]    IR;
    logic             N;
    logic             Z;
    logic             C;
    logic             mem_rdy;
    logic             resume;
    logic [RA_W-1:0]  W_addr;
    logic [RA_W-1:0]  R_addr;
    logic [RA_W-1:0]  S_addr;
    logic             adr_sel;
    logic             s_sel;
    logic             pc_ld;
    logic             pc_inc;
    logic             pc_sel;
    logic             ir_ld;
    logic             mw_en;
    logic             rw_en;
    logic [3:0]       alu_op;
    logic             mem_req;
    logic             bus_err;
    logic [7:0]       status;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  IR, N, Z, C, mem_rdy, resume,
        output W_addr, R_addr, S_addr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld,
               mw_en, rw_en, alu_op, mem_req, bus_err, status, instr_cnt
    );

    modport slave (
        output IR, N, Z, C, mem_rdy, resume,
        input  W_addr, R_addr, S_addr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld,
               mw_en, rw_en, alu_op, mem_req, bus_err, status, instr_cnt
    );
endinterface

// File: rtl/cpu_cu_ws.sv
// Multi-cycle control unit: fetch/decode/execute FSM with memory wait-state timeout,
// resumable HALT, sticky bus error and a retired-instruction counter.
module cpu_cu_ws #(
    parameter int unsigned RA_W     = 3,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 16
) (
    input logic         clk,
    input logic         reset_n,
    cpu_cu_ws_if.master bus
);
    localparam int unsigned IW       = 7 + 3 * RA_W;
    localparam logic [7:0]  WaitLast = 8'(WAIT_MAX - 1);

    typedef enum logic [4:0] {
        StReset, StFetch, StDecode,
        StAdd, StSub, StCmp, StMov, StShl, StShr, StInc, StDec,
        StLoad, StSto, StLdi, StHalt, StJe, StJne, StJc, StJmp,
        StIllegal, StBusErr
    } state_e;

    state_e           state_q, state_d, dec_state;
    logic [2:0]       ps_q, ps_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    logic [6:0]       opcode;
    logic [RA_W-1:0]  f_w, f_r, f_s;
    logic             is_alu, is_mem, is_jmp, timeout;

    assign opcode = bus.IR[IW-1 -: 7];
    assign f_w    = bus.IR[3*RA_W-1 -: RA_W];
    assign f_r    = bus.IR[2*RA_W-1 -: RA_W];
    assign f_s    = bus.IR[RA_W-1:0];

    assign is_alu  = state_q inside {StAdd, StSub, StCmp, StMov, StShl, StShr, StInc, StDec};
    assign is_mem  = state_q inside {StFetch, StLoad, StSto, StLdi};
    assign is_jmp  = state_q inside {StJe, StJne, StJc, StJmp};
    // A ready on the last allowed wait cycle still completes the access.
    assign timeout = is_mem && !bus.mem_rdy && (wait_q == WaitLast);

    always_comb begin
        unique case (opcode)
            7'h70:   dec_state = StAdd;
            7'h71:   dec_state = StSub;
            7'h72:   dec_state = StCmp;
            7'h73:   dec_state = StMov;
            7'h74:   dec_state = StShl;
            7'h75:   dec_state = StShr;
            7'h76:   dec_state = StInc;
            7'h77:   dec_state = StDec;
            7'h78:   dec_state = StLoad;
            7'h79:   dec_state = StSto;
            7'h7A:   dec_state = StLdi;
            7'h7B:   dec_state = StHalt;
            7'h7C:   dec_state = StJe;
            7'h7D:   dec_state = StJne;
            7'h7E:   dec_state = StJc;
            7'h7F:   dec_state = StJmp;
            default: dec_state = StIllegal;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StReset;
            ps_q      <= 3'b000;
            wait_q    <= 8'd0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ps_q      <= ps_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset:  state_d = StFetch;
            StFetch: begin
                if (bus.mem_rdy)  state_d = StDecode;
                else if (timeout) state_d = StBusErr;
            end
            StDecode: state_d = dec_state;
            StLoad, StSto, StLdi: begin
                if (bus.mem_rdy)  state_d = StFetch;
                else if (timeout) state_d = StBusErr;
            end
            StHalt:   if (bus.resume) state_d = StFetch;
            StIllegal, StBusErr: state_d = state_q;
            default:  state_d = StFetch;  // single-cycle ALU and branch states
        endcase
    end

    always_comb begin
        ps_d = ps_q;
        if (is_alu && (state_q != StMov)) ps_d = {bus.N, bus.Z, bus.C};

        wait_d = 8'd0;
        if (is_mem && !bus.mem_rdy && (state_d == state_q)) wait_d = wait_q + 8'd1;

        cnt_d = cnt_q;
        if (is_alu || is_jmp || (is_mem && (state_q != StFetch) && bus.mem_rdy) ||
            ((state_q == StDecode) && (state_d == StHalt))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        bus_err_d = bus_err_q | (state_d == StBusErr);
    end

    assign bus.bus_err   = bus_err_q;
    assign bus.instr_cnt = cnt_q;

    always_comb begin
        bus.W_addr  = '0;
        bus.R_addr  = '0;
        bus.S_addr  = '0;
        bus.adr_sel = 1'b0;
        bus.s_sel   = 1'b0;
        bus.pc_ld   = 1'b0;
        bus.pc_inc  = 1'b0;
        bus.pc_sel  = 1'b0;
        bus.ir_ld   = 1'b0;
        bus.mw_en   = 1'b0;
        bus.rw_en   = 1'b0;
        bus.alu_op  = 4'b0000;
        bus.mem_req = 1'b0;
        bus.status  = 8'h00;

        if (is_alu) begin
            bus.W_addr = f_w;
            bus.R_addr = f_r;
            bus.S_addr = f_s;
            bus.rw_en  = (state_q != StCmp);
        end

        case (state_q)
            StReset:  bus.status = 8'hFF;
            StFetch: begin
                bus.mem_req = 1'b1;
                bus.ir_ld   = bus.mem_rdy;
                bus.pc_inc  = bus.mem_rdy;
                bus.status  = 8'h80;
            end
            StDecode: bus.status = 8'hC0;
            StAdd: begin bus.alu_op = 4'b0100; bus.status = {ps_q, 5'd0}; end
            StSub: begin bus.alu_op = 4'b0101; bus.status = {ps_q, 5'd1}; end
            StCmp: begin bus.alu_op = 4'b0101; bus.status = {ps_q, 5'd2}; end
            StMov: begin bus.alu_op = 4'b0000; bus.status = {ps_q, 5'd3}; end
            StShl: begin bus.alu_op = 4'b0111; bus.status = {ps_q, 5'd4}; end
            StShr: begin bus.alu_op = 4'b0110; bus.status = {ps_q, 5'd5}; end
            StInc: begin bus.alu_op = 4'b0010; bus.status = {ps_q, 5'd6}; end
            StDec: begin bus.alu_op = 4'b0011; bus.status = {ps_q, 5'd7}; end
            StLoad: begin
                bus.adr_sel = 1'b1;
                bus.s_sel   = 1'b1;
                bus.R_addr  = f_s;
                bus.W_addr  = f_w;
                bus.mem_req = 1'b1;
                bus.rw_en   = bus.mem_rdy;
                bus.status  = {ps_q, 5'd8};
            end
            StSto: begin
                bus.adr_sel = 1'b1;
                bus.R_addr  = f_w;
                bus.S_addr  = f_s;
                bus.mem_req = 1'b1;
                bus.mw_en   = 1'b1;
                bus.status  = {ps_q, 5'd9};
            end
            StLdi: begin
                bus.s_sel   = 1'b1;
                bus.W_addr  = f_w;
                bus.mem_req = 1'b1;
                bus.rw_en   = bus.mem_rdy;
                bus.pc_inc  = bus.mem_rdy;
                bus.status  = {ps_q, 5'd10};
            end
            StHalt: bus.status = {ps_q, 5'b01011};
            StJe:  begin bus.pc_ld = ps_q[1];  bus.status = {ps_q, 5'd12}; end
            StJne: begin bus.pc_ld = ~ps_q[1]; bus.status = {ps_q, 5'd13}; end
            StJc:  begin bus.pc_ld = ps_q[0];  bus.status = {ps_q, 5'd14}; end
            StJmp: begin
                bus.pc_ld  = 1'b1;
                bus.pc_sel = 1'b1;
                bus.S_addr = f_s;
                bus.status = {ps_q, 5'd15};
            end
            StIllegal: bus.status = 8'hF0;
            StBusErr:  bus.status = 8'hE0;
            default: ;
        endcase
    end
endmodule
